// File: rtl/gb_interrupt_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, fixed-priority dispatch to the CPU
// through a two-state request/acknowledge handshake, and a HALT/STOP wake flag.
module gb_interrupt_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_i,
    input  logic [15:0] addr,
    input  logic        wren,
    output logic [7:0]  data_o,
    input  logic        irq_vblank,
    input  logic        irq_stat,
    input  logic        irq_timer,
    input  logic        irq_serial,
    input  logic        irq_joypad,
    input  logic        ime_i,
    input  logic        int_ack,
    output logic        int_req,
    output logic [7:0]  int_vector,
    output logic        wake
);

    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  if_reg, if_next;
    logic [7:0]  ie_reg, ie_next;
    logic [2:0]  idx_reg, idx_next;
    logic [7:0]  vec_reg, vec_next;

    logic [4:0]  src;
    logic [4:0]  pending;
    logic [4:0]  ack_clr_mask;
    logic [2:0]  top_idx;
    logic        any_pending;
    logic        ack_take;
    logic        if_wr;
    logic        ie_wr;

    assign src         = {irq_joypad, irq_serial, irq_timer, irq_stat, irq_vblank};
    assign pending     = ie_reg[4:0] & if_reg;
    assign any_pending = |pending;
    assign if_wr       = wren && (addr == ADDR_IF);
    assign ie_wr       = wren && (addr == ADDR_IE);

    // Descending scan so the lowest pending index (vblank) is the last to win.
    always_comb begin
        top_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pending[i]) begin
                top_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        vec_next   = vec_reg;
        ack_take   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ime_i && any_pending) begin
                    state_next = REQ;
                    idx_next   = top_idx;
                    vec_next   = 8'h40 + {2'b00, top_idx, 3'b000};
                end
            end
            REQ: begin
                // A cancelled request (source cleared/disabled or IME dropped) swallows any ack.
                if (!ime_i || !pending[idx_reg]) begin
                    state_next = IDLE;
                end else if (int_ack) begin
                    ack_take   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per bit: ack clear, then CPU write overrides, then new source requests are OR-ed on top.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_if_bit
            assign ack_clr_mask[gi] = ack_take && (idx_reg == 3'(gi));
            assign if_next[gi] = src[gi] |
                                 (if_wr ? data_i[gi] : (if_reg[gi] & ~ack_clr_mask[gi]));
        end
    endgenerate

    assign ie_next = ie_wr ? data_i : ie_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            if_reg    <= 5'h00;
            ie_reg    <= 8'h00;
            idx_reg   <= 3'd0;
            vec_reg   <= 8'h00;
        end else begin
            state_reg <= state_next;
            if_reg    <= if_next;
            ie_reg    <= ie_next;
            idx_reg   <= idx_next;
            vec_reg   <= vec_next;
        end
    end

    always_comb begin
        data_o = 8'hFF;
        if (addr == ADDR_IF) begin
            data_o = {3'b111, if_reg};
        end else if (addr == ADDR_IE) begin
            data_o = ie_reg;
        end
    end

    assign int_req    = (state_reg == REQ);
    assign int_vector = vec_reg;
    assign wake       = any_pending;

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// Scoreboard bench for gb_interrupt_ctrl: the driver steps a behavioural model and queues the
// expected post-edge view; a monitor pops one entry per clock edge and compares.
module tb_gb_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_i;
    logic [15:0] addr;
    logic        wren;
    logic [7:0]  data_o;
    logic        irq_vblank, irq_stat, irq_timer, irq_serial, irq_joypad;
    logic        ime_i;
    logic        int_ack;
    logic        int_req;
    logic [7:0]  int_vector;
    logic        wake;

    gb_interrupt_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .data_i     (data_i),
        .addr       (addr),
        .wren       (wren),
        .data_o     (data_o),
        .irq_vblank (irq_vblank),
        .irq_stat   (irq_stat),
        .irq_timer  (irq_timer),
        .irq_serial (irq_serial),
        .irq_joypad (irq_joypad),
        .ime_i      (ime_i),
        .int_ack    (int_ack),
        .int_req    (int_req),
        .int_vector (int_vector),
        .wake       (wake)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       req;
        bit [7:0] vec;
        bit [7:0] rd;
        bit       wk;
        int       id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    // Reference model: interrupt flags, enables, and the outstanding dispatch (if any).
    bit [4:0] m_if;
    bit [7:0] m_ie;
    bit       m_req;
    int       m_idx;
    bit [7:0] m_vec;

    function automatic bit [7:0] m_read(input bit [15:0] a);
        if (a == 16'hFF0F) return {3'b111, m_if};
        if (a == 16'hFFFF) return m_ie;
        return 8'hFF;
    endfunction

    function automatic void model_step(input bit rst, input bit w, input bit [15:0] a,
                                       input bit [7:0] d, input bit [4:0] s,
                                       input bit ime, input bit ack);
        bit [4:0] pend;
        bit       clr;
        int       n;
        if (!rst) begin
            m_if = '0; m_ie = '0; m_req = 1'b0; m_idx = 0; m_vec = '0;
            return;
        end
        pend = m_ie[4:0] & m_if;
        clr  = 1'b0;
        if (!m_req) begin
            if (ime && pend != 0) begin
                n = 0;
                while (!pend[n]) n++;
                m_req = 1'b1;
                m_idx = n;
                m_vec = 8'(64 + 8 * n);
            end
        end else if (!ime || !pend[m_idx]) begin
            m_req = 1'b0;
        end else if (ack) begin
            m_req = 1'b0;
            clr   = 1'b1;
        end
        if (clr) m_if[m_idx] = 1'b0;
        if (w && a == 16'hFF0F) m_if = d[4:0];
        m_if |= s;
        if (w && a == 16'hFFFF) m_ie = d;
    endfunction

    function automatic void check(input string name, input int id,
                                  input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
        end
    endfunction

    // One clock of stimulus: drive at the falling edge, model the next rising edge, queue result.
    task automatic cycle(input bit rst, input bit w, input bit [15:0] a, input bit [7:0] d,
                         input bit [4:0] s, input bit ime, input bit ack);
        exp_t e;
        @(negedge clk);
        reset = rst; wren = w; addr = a; data_i = d; ime_i = ime; int_ack = ack;
        {irq_joypad, irq_serial, irq_timer, irq_stat, irq_vblank} = s;
        model_step(rst, w, a, d, s, ime, ack);
        e.req = m_req;
        e.vec = m_vec;
        e.rd  = m_read(a);
        e.wk  = |(m_ie[4:0] & m_if);
        e.id  = step++;
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit ime, input bit [15:0] a);
        cycle(1'b1, 1'b0, a, 8'h00, 5'h00, ime, 1'b0);
    endtask

    task automatic wr(input bit [15:0] a, input bit [7:0] d, input bit [4:0] s, input bit ime);
        cycle(1'b1, 1'b1, a, d, s, ime, 1'b0);
    endtask

    task automatic ack(input bit ime);
        cycle(1'b1, 1'b0, 16'hFF0F, 8'h00, 5'h00, ime, 1'b1);
    endtask

    // Monitor: one expected entry per rising edge, sampled just after it.
    bit prev_req = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("int_req", e.id, {7'b0, int_req}, {7'b0, e.req});
                if (e.req) check("int_vector", e.id, int_vector, e.vec);
                check("data_o", e.id, data_o, e.rd);
                check("wake", e.id, {7'b0, wake}, {7'b0, e.wk});
                if (int_req && !prev_req)
                    $display("dispatch step %0d vector %h", e.id, int_vector);
                prev_req = int_req;
            end
        end
    end

    initial begin
        bit        w, a_ack, ime;
        bit [15:0] a;
        bit [4:0]  s;
        reset = 1'b0; wren = 1'b0; addr = 16'hFF0F; data_i = 8'h00; ime_i = 1'b0;
        int_ack = 1'b0;
        {irq_joypad, irq_serial, irq_timer, irq_stat, irq_vblank} = 5'h00;
        model_step(1'b0, 1'b0, 16'h0, 8'h0, 5'h0, 1'b0, 1'b0);

        #1;
        check("reset_int_req", -1, {7'b0, int_req}, 8'h00);
        check("reset_if", -1, data_o, 8'hE0);

        repeat (3) cycle(1'b0, 1'b0, 16'hFFFF, 8'h00, 5'h00, 1'b1, 1'b0);

        // Timer dispatch and acknowledge.
        wr(16'hFFFF, 8'h04, 5'h00, 1'b1);
        cycle(1'b1, 1'b0, 16'hFF0F, 8'h00, 5'b00100, 1'b1, 1'b0);
        idle(1'b1, 16'hFF0F);
        ack(1'b1);
        idle(1'b1, 16'hFF0F);

        // Simultaneous serial + vblank: vblank first, one gap cycle, then serial.
        wr(16'hFFFF, 8'h1F, 5'h00, 1'b1);
        cycle(1'b1, 1'b0, 16'hFF0F, 8'h00, 5'b01001, 1'b1, 1'b0);
        idle(1'b1, 16'hFF0F);
        ack(1'b1);
        idle(1'b1, 16'hFF0F);
        ack(1'b1);
        idle(1'b1, 16'hFF0F);

        // IME low: wake without request, then dispatch once IME rises.
        wr(16'hFFFF, 8'h04, 5'h00, 1'b0);
        cycle(1'b1, 1'b0, 16'hFF0F, 8'h00, 5'b00100, 1'b0, 1'b0);
        repeat (10) idle(1'b0, 16'hFF0F);
        idle(1'b1, 16'hFF0F);
        ack(1'b1);

        // Cancellation by IF write; the following ack must not touch IF.
        cycle(1'b1, 1'b0, 16'hFF0F, 8'h00, 5'b00100, 1'b1, 1'b0);
        idle(1'b1, 16'hFF0F);
        wr(16'hFF0F, 8'h00, 5'h00, 1'b1);
        ack(1'b1);
        idle(1'b1, 16'hFF0F);

        // Write-versus-set collision, IE readback, unmapped read.
        wr(16'hFF0F, 8'h00, 5'b10000, 1'b1);
        wr(16'hFFFF, 8'hA5, 5'h00, 1'b1);
        idle(1'b1, 16'hFF05);
        wr(16'hFF0F, 8'h00, 5'h00, 1'b1);

        // Asynchronous reset while a request is outstanding.
        wr(16'hFFFF, 8'h04, 5'h00, 1'b1);
        cycle(1'b1, 1'b0, 16'hFF0F, 8'h00, 5'b00100, 1'b1, 1'b0);
        idle(1'b1, 16'hFF0F);
        @(posedge clk);
        #3;
        reset = 1'b0;
        addr  = 16'hFF0F;
        model_step(1'b0, 1'b0, 16'h0, 8'h0, 5'h0, 1'b0, 1'b0);
        #1;
        check("async_int_req", step, {7'b0, int_req}, 8'h00);
        check("async_if", step, data_o, 8'hE0);
        check("async_wake", step, {7'b0, wake}, 8'h00);
        addr = 16'hFFFF;
        #1;
        check("async_ie", step, data_o, 8'h00);
        repeat (2) cycle(1'b0, 1'b0, 16'hFF0F, 8'h00, 5'h00, 1'b1, 1'b0);
        repeat (5) idle(1'b1, 16'hFF0F);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            w = ($urandom % 8) == 0;
            case ($urandom % 4)
                0:       a = 16'hFF0F;
                1:       a = 16'hFFFF;
                2:       a = 16'hFF05;
                default: a = 16'($urandom);
            endcase
            for (int b = 0; b < 5; b++) s[b] = ($urandom % 8) == 0;
            ime   = ($urandom % 5) != 0;
            a_ack = m_req ? bit'($urandom % 2) : (($urandom % 10) == 0);
            if (w && a == 16'hFF0F) a_ack = 1'b0;
            cycle(1'b1, w, a, 8'($urandom), s, ime, a_ack);
        end

        @(posedge clk);
        #2;
        check("queue_drained", step, 8'(exp_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gb_interrupt_ctrl.md
GB_INTERRUPT_CTRL -- requirements
Module: gb_interrupt_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
REQ-003 SHALL have port: data_i  input  8  CPU write data.
REQ-004 SHALL have port: addr  input  16  CPU bus address.
REQ-005 SHALL have port: wren  input  1  CPU write strobe, sampled at rising clk.
REQ-006 SHALL have port: data_o  output  8  read data for addr (combinational from registers).
REQ-007 SHALL have ports: irq_vblank, irq_stat, irq_timer, irq_serial, irq_joypad  input  1 each  source request pulses (IF bits 0..4 respectively; irq_timer driven by gb_timer).
REQ-008 SHALL have port: ime_i  input  1  CPU interrupt master enable.
REQ-009 SHALL have port: int_ack  input  1  CPU dispatch acknowledge, one-cycle pulse.
REQ-010 SHALL have port: int_req  output  1  registered dispatch request to CPU.
REQ-011 SHALL have port: int_vector  output  8  registered dispatch address, valid while int_req=1.
REQ-012 SHALL have port: wake  output  1  HALT/STOP wake; high when (IE & IF & 5'h1F) != 0, independent of ime_i.

Function
REQ-013 SHALL hold IF as 5-bit register (addr 16'hFF0F) and IE as 8-bit register (addr 16'hFFFF).
REQ-014 SHALL read FF0F as {3'b111, IF}, FFFF as IE, any other addr as 8'hFF.
REQ-015 SHALL write IF <= data_i[4:0] on wren at FF0F; data_i[7:5] ignored.
REQ-016 SHALL write IE <= data_i on wren at FFFF (all 8 bits stored and read back).
REQ-017 SHALL set IF[n] on any rising clk where source n is high; set visible the cycle after the edge.
REQ-018 Simultaneous IF write and source set: SHALL apply write, then OR in sources (set wins).
REQ-019 pending = IE[4:0] & IF; priority SHALL be lowest bit index first (vblank highest).
REQ-020 Vector SHALL be 8'h40 + 8*n for bit n: 40, 48, 50, 58, 60.
REQ-021 FSM SHALL have two states, IDLE and REQ; int_req = (state == REQ).
REQ-022 IDLE: if ime_i=1 and pending!=0 at edge, SHALL go to REQ and latch int_vector and bit index of highest-priority pending bit.
REQ-023 REQ: int_vector SHALL hold latched value even if higher-priority bit becomes pending.
REQ-024 REQ with int_ack=1 SHALL clear IF[latched] and go to IDLE at the same edge.
REQ-025 REQ: if pending[latched] is 0 at an edge (IF/IE write cancellation) or ime_i=0, SHALL go to IDLE without clearing IF; an int_ack in that cycle SHALL be ignored.
REQ-026 int_ack in IDLE SHALL be ignored (no IF change).
REQ-027 int_ack clear and same-source set in the same cycle: IF bit SHALL remain 1 (set wins).
REQ-028 Latency: source pulse sampled at edge N -> IF bit at N; int_req high after edge N+1 (ime_i=1, IE bit set); wake high after N.
REQ-029 After ack at edge M with further pending bits and ime_i=1: SHALL re-enter REQ at edge M+1 (int_req low for exactly one cycle).

Reset
REQ-030 While reset=0: IF=5'h00, IE=8'h00, state IDLE, int_req=0, int_vector=8'h00; wake=0.
REQ-031 Reset assertion mid-REQ SHALL drop int_req asynchronously; no IF clear recorded.
REQ-032 First state update after release SHALL occur at the first rising clk with reset=1.

Verification
REQ-033 Reset, write FFFF<=8'h04, ime_i=1, pulse irq_timer one cycle -> FF0F reads 8'hE4, int_req=1 one cycle later, int_vector=8'h50; int_ack -> FF0F reads 8'hE0, int_req=0.
REQ-034 IE=8'h1F, ime_i=1, pulse irq_serial and irq_vblank same cycle -> vector 8'h40; ack -> one cycle int_req low, then vector 8'h58; ack -> FF0F=8'hE0.
REQ-035 IE=8'h04, ime_i=0, pulse irq_timer -> wake=1, int_req stays 0 for 10 cycles; raise ime_i -> int_req next edge, vector 8'h50.
REQ-036 In REQ for timer, write FF0F<=8'h00 -> int_req drops next edge; int_ack that cycle leaves IF unchanged; FF0F=8'hE0.
REQ-037 Write FF0F<=8'h00 in same cycle irq_joypad pulses -> FF0F reads 8'hF0; write FFFF<=8'hA5 -> reads 8'hA5; read FF05 -> 8'hFF.
REQ-038 Assert reset low mid-REQ, between clk edges -> int_req, IF, IE zero immediately; after release, no request until new source pulse.
